// File: rtl/cmam_cmd_seq.sv
// Register-command sequencer: buffers host read/write commands and replays them
// one at a time onto the CMAM register port with fixed spacing and read latency.
module cmam_cmd_seq #(
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [6:0]               cmd_addr,
  input  logic [31:0]              cmd_wdata,
  output logic                     rsp_valid,
  output logic [6:0]               rsp_addr,
  output logic [31:0]              rsp_rdata,
  output logic [6:0]               addr,
  output logic [31:0]              data_wr,
  output logic                     wren,
  output logic                     rden,
  input  logic [31:0]              data_rd,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (RD_LAT > GAP) ? RD_LAT : GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef struct packed {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  localparam state_t        AFTER  = (GAP == 0) ? S_IDLE : S_GAP;
  localparam logic [CW-1:0] GAP_LD = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam logic [CW-1:0] RD_LD  = CW'(RD_LAT - 1);

  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   lvl_q;
  logic            rstb_q;
  logic            push, pop;
  cmd_t            head;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            iswr_q, iswr_d;
  logic [6:0]      addr_q, addr_d, rsp_addr_q, rsp_addr_d;
  logic [31:0]     wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic            wren_q, wren_d, rden_q, rden_d, rsp_valid_q, rsp_valid_d;

  assign cmd_ready  = rstb_q & (lvl_q != LW'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign head       = mem_q[rptr_q];
  assign fifo_level = lvl_q;
  assign busy       = (lvl_q != '0) | (state_q != S_IDLE);

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      rstb_q <= 1'b0;
    end else begin
      rstb_q <= 1'b1;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      lvl_q <= lvl_q + LW'(push) - LW'(pop);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    iswr_d      = iswr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wren_d      = 1'b0;
    rden_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lvl_q != '0) begin
          // Strobes are registered here so they are high exactly during ISSUE.
          pop     = 1'b1;
          addr_d  = head.addr;
          wdata_d = head.wdata;
          iswr_d  = head.wr;
          wren_d  = head.wr;
          rden_d  = ~head.wr;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (iswr_q) begin
          state_d = AFTER;
          cnt_d   = GAP_LD;
        end else begin
          state_d = S_WAIT;
          cnt_d   = RD_LD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_rdata_d = data_rd;
          state_d     = AFTER;
          cnt_d       = GAP_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      iswr_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      iswr_q      <= iswr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign addr      = addr_q;
  assign data_wr   = wdata_q;
  assign wren      = wren_q;
  assign rden      = rden_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_cmam_cmd_seq.sv
// Bench for cmam_cmd_seq: directed and random command streams checked against a
// timing/ordering model built from acceptance cycles, plus a CMAM read-data model.
module tb_cmam_cmd_seq;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 2;
  localparam int GAP    = 1;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int MAXC   = 8192;

  typedef struct packed {
    logic [31:0] c;
    logic        wr;
    logic [6:0]  a;
    logic [31:0] d;
  } ev_t;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_wr = 1'b0;
  logic [6:0]    cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [31:0]   data_rd = '0;
  logic          cmd_ready, rsp_valid, wren, rden, busy;
  logic [6:0]    rsp_addr, addr;
  logic [31:0]   rsp_rdata, data_wr;
  logic [LW-1:0] fifo_level;

  cmam_cmd_seq #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk(clk), .rstb(rstb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .addr(addr), .data_wr(data_wr), .wren(wren), .rden(rden),
    .data_rd(data_rd), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  ev_t obs_iss[$], obs_rsp[$], exp_iss[$], exp_rsp[$];
  int rd_c[$];
  logic [6:0] rd_a[$];
  logic [LW-1:0] lvl_a [MAXC];
  logic rdy_a [MAXC];
  int acc_q[$], pop_q[$];
  int next_free = 0, win_start = 0, last_acc = 0;

  function automatic logic [31:0] rdfun(input logic [6:0] a);
    return {16'hA5A5, 9'h000, a};
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe the CMAM side and play the register block: data is valid only RD_LAT cycles after rden.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      lvl_a[cyc] = fifo_level;
      rdy_a[cyc] = cmd_ready;
    end
    if (wren) obs_iss.push_back(ev_t'{c: 32'(cyc), wr: 1'b1, a: addr, d: data_wr});
    if (rden) begin
      obs_iss.push_back(ev_t'{c: 32'(cyc), wr: 1'b0, a: addr, d: 32'h0});
      rd_c.push_back(cyc);
      rd_a.push_back(addr);
    end
    if (rsp_valid) obs_rsp.push_back(ev_t'{c: 32'(cyc), wr: 1'b0, a: rsp_addr, d: rsp_rdata});
    data_rd = $urandom;
    while (rd_c.size() > 0 && rd_c[0] + RD_LAT < cyc) begin
      void'(rd_c.pop_front());
      void'(rd_a.pop_front());
    end
    if (rd_c.size() > 0 && rd_c[0] + RD_LAT == cyc) data_rd = rdfun(rd_a[0]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_addr  = 7'($urandom);
    cmd_wdata = $urandom;
  endtask

  // Issue = max(accept+2, previous issue + its spacing); reads respond RD_LAT+1 after issue.
  task automatic push(input logic wr, input logic [6:0] a, input logic [31:0] d);
    int n = 0;
    int iss;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    chk("push_wait", 96'(n < 100), 96'd1);
    last_acc = cyc;
    iss = (cyc + 2 > next_free) ? cyc + 2 : next_free;
    exp_iss.push_back(ev_t'{c: 32'(iss), wr: wr, a: a, d: wr ? d : 32'h0});
    if (!wr) exp_rsp.push_back(ev_t'{c: 32'(iss + RD_LAT + 1), wr: 1'b0, a: a, d: rdfun(a)});
    next_free = iss + (wr ? 2 + GAP : RD_LAT + 2 + GAP);
    acc_q.push_back(cyc);
    pop_q.push_back(iss - 1);
    tick();
  endtask

  task automatic drain(input string tag, input bit do_lvl);
    int last = cyc;
    int n = 0;
    foreach (exp_iss[i]) if (int'(exp_iss[i].c) > last) last = int'(exp_iss[i].c);
    foreach (exp_rsp[i]) if (int'(exp_rsp[i].c) > last) last = int'(exp_rsp[i].c);
    while (cyc < last + RD_LAT + GAP + 4 && n < 1000) begin tick(); n++; end
    chk({tag, "_timeout"}, 96'(n < 1000), 96'd1);
    chk({tag, "_niss"}, 96'(obs_iss.size()), 96'(exp_iss.size()));
    for (int i = 0; i < obs_iss.size() && i < exp_iss.size(); i++) begin
      chk({tag, "_iss_cyc"}, 96'(obs_iss[i].c), 96'(exp_iss[i].c));
      chk({tag, "_iss_cmd"}, 96'({obs_iss[i].wr, obs_iss[i].a, obs_iss[i].d}),
                             96'({exp_iss[i].wr, exp_iss[i].a, exp_iss[i].d}));
    end
    chk({tag, "_nrsp"}, 96'(obs_rsp.size()), 96'(exp_rsp.size()));
    for (int i = 0; i < obs_rsp.size() && i < exp_rsp.size(); i++) begin
      chk({tag, "_rsp_cyc"}, 96'(obs_rsp[i].c), 96'(exp_rsp[i].c));
      chk({tag, "_rsp_dat"}, 96'({obs_rsp[i].a, obs_rsp[i].d}), 96'({exp_rsp[i].a, exp_rsp[i].d}));
    end
    if (do_lvl) begin
      for (int k = win_start; k < cyc && k < MAXC; k++) begin
        int e = 0;
        foreach (acc_q[j]) if (acc_q[j] < k) e++;
        foreach (pop_q[j]) if (pop_q[j] < k) e--;
        chk({tag, "_lvl"}, 96'(lvl_a[k]), 96'(e));
        chk({tag, "_rdy"}, 96'(rdy_a[k]), 96'(e != DEPTH));
      end
    end
    chk({tag, "_busy_end"}, 96'(busy), 96'd0);
    obs_iss.delete(); exp_iss.delete(); obs_rsp.delete(); exp_rsp.delete();
    acc_q.delete(); pop_q.delete();
    win_start = cyc;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_rdy"},   96'(cmd_ready),  96'd0);
    chk({tag, "_wren"},  96'(wren),       96'd0);
    chk({tag, "_rden"},  96'(rden),       96'd0);
    chk({tag, "_rspv"},  96'(rsp_valid),  96'd0);
    chk({tag, "_busy"},  96'(busy),       96'd0);
    chk({tag, "_addr"},  96'(addr),       96'd0);
    chk({tag, "_wdat"},  96'(data_wr),    96'd0);
    chk({tag, "_rspa"},  96'(rsp_addr),   96'd0);
    chk({tag, "_rspd"},  96'(rsp_rdata),  96'd0);
    chk({tag, "_lvl"},   96'(fifo_level), 96'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a4;
    idle();
    rstb = 1'b0;
    tick(); tick(); tick();
    reset_vals("rst0");
    rstb = 1'b1;
    chk("rst0_rdy_release", 96'(cmd_ready), 96'd0);
    tick();
    chk("rst0_rdy_on", 96'(cmd_ready), 96'd1);
    win_start = cyc;
    next_free = 0;

    // single write, then single read
    push(1'b1, 7'h05, 32'hDEADBEEF); idle(); drain("wr1", 1);
    push(1'b0, 7'h12, $urandom);     idle(); drain("rd1", 1);

    // six back-to-back writes: FIFO fills and back-pressures
    for (int i = 0; i < 6; i++) push(1'b1, 7'(8'h20 + i), $urandom);
    idle(); drain("full", 1);

    // interleaved write/read/write/read
    push(1'b1, 7'h30, $urandom); push(1'b0, 7'h31, $urandom);
    push(1'b1, 7'h32, $urandom); push(1'b0, 7'h33, $urandom);
    idle(); drain("mix", 1);

    // push coinciding with pop at level 2, then enough commands to wrap the pointers
    push(1'b1, 7'h40, $urandom); push(1'b1, 7'h41, $urandom); push(1'b1, 7'h42, $urandom);
    idle(); tick();
    push(1'b1, 7'h43, $urandom);
    a4 = last_acc;
    for (int i = 4; i < 9; i++) push(1'b1, 7'(8'h40 + i), $urandom);
    idle();
    chk("pushpop_lvl_before", 96'(lvl_a[a4]), 96'd2);
    chk("pushpop_lvl_after", 96'(lvl_a[a4 + 1]), 96'd2);
    drain("wrap", 1);

    // reset during the WAIT phase of a read
    push(1'b0, 7'h44, $urandom); idle();
    n = 0;
    while (!rden && n < 20) begin tick(); n++; end
    chk("rst1_rden_seen", 96'(n < 20), 96'd1);
    tick();
    chk("rst1_busy_wait", 96'(busy), 96'd1);
    rstb = 1'b0;
    tick();
    reset_vals("rst1");
    rstb = 1'b1;
    tick();
    chk("rst1_rdy_on", 96'(cmd_ready), 96'd1);
    exp_rsp.delete();
    next_free = 0;
    drain("rst1", 0);
    push(1'b1, 7'h55, 32'h1234_5678); idle(); drain("post", 1);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      push(1'($urandom_range(0, 1)), 7'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 4)) tick();
      end
    end
    idle(); drain("rand", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmam_cmd_seq.md
# cmam_cmd_seq

Register-command sequencer directly upstream of the CMAM register port. Accepts host register read/write commands through a valid/ready handshake and buffers them in a small FIFO. Replays them one at a time onto the CMAM `addr`/`data_wr`/`wren`/`rden` interface with fixed spacing, captures `data_rd` after a fixed read latency, and returns each read result as a single-cycle response pulse.

## Interface

Parameters:
- `DEPTH`, 4: command FIFO depth (power of 2, ≥2)
- `RD_LAT`, 2: cycles from the `rden` cycle to the cycle `data_rd` is valid (≥1)
- `GAP`, 1: idle cycles enforced after each transaction before the next issue (≥0)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rstb` in 1: synchronous, active-low reset
- `cmd_valid` in 1: host command valid
- `cmd_ready` out 1: FIFO can accept a command
- `cmd_wr` in 1: 1 = write, 0 = read
- `cmd_addr` in 7: register address
- `cmd_wdata` in 32: write data (ignored for reads)
- `rsp_valid` out 1: one-cycle pulse, read data available
- `rsp_addr` out 7: address of the completed read
- `rsp_rdata` out 32: captured read data
- `addr` out 7: to CMAM register address
- `data_wr` out 32: to CMAM write data
- `wren` out 1: to CMAM write enable, one-cycle pulse
- `rden` out 1: to CMAM read enable, one-cycle pulse
- `data_rd` in 32: from CMAM read data
- `busy` out 1: FIFO non-empty or state ≠ IDLE
- `fifo_level` out log2(DEPTH)+1: current FIFO occupancy

## Operation

- FIFO:
  - Push on `cmd_valid & cmd_ready`.
  - `cmd_ready = rstb_q & (fifo_level != DEPTH)`, where `rstb_q` is a registered reset-release flag.
  - Push and pop in the same cycle are legal; the level is unchanged.
  - A push while full cannot occur.
- State machine (all CMAM-side outputs are registered):
  - IDLE:
    - If the FIFO is non-empty: pop the head, load `addr`/`data_wr`, and go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - Drive `wren` = `cmd_wr` or `rden` = `!cmd_wr` for exactly this cycle.
    - Write → GAP (or IDLE if `GAP` = 0).
    - Read → WAIT; the counter loads `RD_LAT`-1.
  - WAIT:
    - Decrement the counter each cycle.
    - When the counter = 0, register `data_rd` into `rsp_rdata` and `addr` into `rsp_addr`, and assert `rsp_valid` next cycle.
    - Then → GAP (or IDLE if `GAP` = 0).
  - GAP: count `GAP` cycles, then → IDLE.
- `addr`/`data_wr` hold their last issued value until the next pop. There is no pulse on `wren`/`rden` outside ISSUE.
- Exactly one transaction is outstanding at a time. Commands complete in FIFO order.
- `rsp_valid` has no backpressure. The host must sample it on the pulse.
- Reset (`rstb` low at any edge, including mid-transaction):
  - Flush the FIFO and return to IDLE.
  - Abandon any in-flight read with no response.
  - Zero all counters.

## Timing

- Reset values: `cmd_ready`=0 while `rstb`=0 and for the first cycle after release, then 1. `rsp_valid`, `wren`, `rden`, `busy`=0. `addr`=0, `data_wr`=0, `rsp_addr`=0, `rsp_rdata`=0, `fifo_level`=0.
- Command accepted at edge T into an empty FIFO with state IDLE: pop at T+1, `wren`/`rden` high during cycle T+2.
- Read: `rden` in cycle R; `data_rd` sampled at the end of cycle R+`RD_LAT`; `rsp_valid` high in cycle R+`RD_LAT`+1.
- Issue-to-issue spacing:
  - Back-to-back writes: `wren` pulses 2+`GAP` cycles apart (ISSUE, GAP×`GAP`, IDLE).
  - Read followed by any command: `RD_LAT`+2+`GAP` cycles.
- `busy` falls in the cycle after the last transaction's final state exits to IDLE with the FIFO empty.

## Test plan

- Reset then single write (`addr`=0x05, `data`=0xDEADBEEF) at cycle T → `wren`=1 only in T+2, `addr`=0x05, `data_wr`=0xDEADBEEF, `rden` never asserts, no `rsp_valid`.
- Read at `addr` 0x12, model returns 0xA5A5_0012 in cycle R+2 (`RD_LAT`=2) → `rden` at R, `rsp_valid` one cycle at R+3 with `rsp_addr`=0x12, `rsp_rdata`=0xA5A50012.
- Push 4 writes back-to-back (`DEPTH`=4), 5th held valid → `cmd_ready` drops after the FIFO fills. The 5th is accepted after the first pop. `wren` pulses are 3 cycles apart (`GAP`=1) in push order.
- Interleaved write/read/write/read at increasing addresses → issue order matches push order. Exactly two `rsp_valid` pulses, each carrying its own address. Spacing per the Timing section.
- Simultaneous push and pop at level 2 → `fifo_level` stays 2 that cycle. Pointer wrap after 9 total commands delivers all in order.
- `rstb` pulled low for one cycle during WAIT of a read → no `rsp_valid`. FIFO empties and outputs return to reset values. The next command after release issues normally at acceptance+2.
